// File: rtl/vga_timing_monitor_if.sv
// Signal bundle between a VGA timing source and vga_timing_monitor.
// SHLOAD_CHECK_EN adds shload_n / shload_err to the bundle.
interface vga_timing_monitor_if;
  logic        hsync;
  logic        vsync;
  logic        blank;
  logic        locked;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        pix_valid;
  logic        frame_stb;
  logic [10:0] h_meas;
  logic [10:0] a_meas;
  logic [8:0]  v_meas;
  logic [7:0]  err_cnt;
`ifdef SHLOAD_CHECK_EN
  logic        shload_n;
  logic        shload_err;

  modport master (
    output hsync, vsync, blank, shload_n,
    input  locked, x, y, pix_valid, frame_stb, h_meas, a_meas, v_meas, err_cnt, shload_err
  );
  modport slave (
    input  hsync, vsync, blank, shload_n,
    output locked, x, y, pix_valid, frame_stb, h_meas, a_meas, v_meas, err_cnt, shload_err
  );
`else
  modport master (
    output hsync, vsync, blank,
    input  locked, x, y, pix_valid, frame_stb, h_meas, a_meas, v_meas, err_cnt
  );
  modport slave (
    input  hsync, vsync, blank,
    output locked, x, y, pix_valid, frame_stb, h_meas, a_meas, v_meas, err_cnt
  );
`endif
endinterface

// File: rtl/vga_timing_monitor.sv
// Sink-side VGA timing checker: measures line/frame geometry, locks on the configured mode,
// reconstructs (x, y) and counts violations. SHLOAD_CHECK_EN enables the shift-load phase check.
//
// state   | meaning
// SEARCH  | waiting for a vsync edge to start a measurement frame
// MEASURE | measuring one full frame; good frame -> LOCKED
// LOCKED  | geometry matches; any bad line/frame or timeout drops to SEARCH
module vga_timing_monitor #(
  parameter int H_TOTAL   = 800,
  parameter int H_ACTIVE  = 640,
  parameter int V_TOTAL   = 449,
  parameter int V_ACTIVE  = 400,
  parameter int HSYNC_ACT = 0,
  parameter int VSYNC_ACT = 1
) (
  input logic                 pclk,
  input logic                 rst_n,
  vga_timing_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [10:0] CNT_MAX = 11'h7ff;
  localparam logic [8:0]  V_MAX   = 9'h1ff;
  localparam logic [9:0]  X_MAX   = 10'h3ff;
  localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
  localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
  localparam logic [8:0]  V_TOT   = 9'(V_TOTAL);
  localparam logic [8:0]  V_ACT   = 9'(V_ACTIVE);
  localparam logic        HS_ACT  = 1'(HSYNC_ACT);
  localparam logic        VS_ACT  = 1'(VSYNC_ACT);

  state_t      state, state_nxt;
  logic        fsm_err;

  logic        hs_r, hs_d, vs_r, vs_d, bl_r;
  logic        hs_edge, vs_edge;
  logic [10:0] h_cnt, act_cnt, h_meas, a_meas, h_period;
  logic [8:0]  v_cnt, va_cnt, v_meas, y;
  logic [9:0]  x;
  logic        h_seen, frame_bad, to_flag, frame_stb;
  logic        line_act, line_bad, frame_good, timeout, to_err;
  logic [7:0]  err_cnt;
  logic [9:0]  err_sum;
  logic        shl_inc;

  assign hs_edge    = (hs_r == HS_ACT) && (hs_d != HS_ACT);
  assign vs_edge    = (vs_r == VS_ACT) && (vs_d != VS_ACT);
  // h_cnt saturates, so a timed-out line reports the ceiling rather than wrapping to 0
  assign h_period   = (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 11'd1;
  assign line_act   = (act_cnt != 11'd0);
  assign line_bad   = hs_edge && h_seen &&
                      ((h_period != H_TOT) || (line_act && (act_cnt != H_ACT)));
  assign frame_good = !frame_bad && (v_cnt == V_TOT) && (va_cnt == V_ACT);
  assign timeout    = (h_cnt == CNT_MAX);
  assign to_err     = timeout && !to_flag;

`ifdef SHLOAD_CHECK_EN
  logic shl_r, shl_line, shload_err, shl_bad;

  // shload_n must be low on the last pixel of every 8-pixel group
  assign shl_bad = !bl_r && (shl_r != (x[2:0] != 3'b111));
  assign shl_inc = shl_bad && !shl_line;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      shl_r      <= 1'b1;
      shl_line   <= 1'b0;
      shload_err <= 1'b0;
    end else begin
      shl_r <= mon.shload_n;
      if (hs_edge)
        shl_line <= 1'b0;
      else if (shl_bad)
        shl_line <= 1'b1;
      if (shl_bad)
        shload_err <= 1'b1;
    end
  end

  assign mon.shload_err = shload_err;
`else
  assign shl_inc = 1'b0;
`endif

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)
      state <= SEARCH;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fsm_err   = 1'b0;
    case (state)
      SEARCH: begin
        if (vs_edge)
          state_nxt = MEASURE;
      end
      MEASURE: begin
        if (vs_edge) begin
          if (frame_good)
            state_nxt = LOCKED;
          else
            fsm_err = 1'b1;
        end
      end
      LOCKED: begin
        if (line_bad || (vs_edge && !frame_good)) begin
          state_nxt = SEARCH;
          fsm_err   = 1'b1;
        end
      end
      default: state_nxt = SEARCH;
    endcase
    // a timeout episode is charged once via to_err, never again by the FSM
    if (timeout) begin
      state_nxt = SEARCH;
      fsm_err   = 1'b0;
    end
  end

  assign err_sum = {2'b00, err_cnt} + 10'(fsm_err) + 10'(to_err) + 10'(shl_inc);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hs_r      <= ~HS_ACT;
      hs_d      <= ~HS_ACT;
      vs_r      <= ~VS_ACT;
      vs_d      <= ~VS_ACT;
      bl_r      <= 1'b1;
      h_cnt     <= '0;
      act_cnt   <= '0;
      h_meas    <= '0;
      a_meas    <= '0;
      v_cnt     <= '0;
      va_cnt    <= '0;
      v_meas    <= '0;
      x         <= '0;
      y         <= '0;
      h_seen    <= 1'b0;
      frame_bad <= 1'b0;
      to_flag   <= 1'b0;
      frame_stb <= 1'b0;
      err_cnt   <= '0;
    end else begin
      hs_r      <= mon.hsync;
      hs_d      <= hs_r;
      vs_r      <= mon.vsync;
      vs_d      <= vs_r;
      bl_r      <= mon.blank;
      frame_stb <= vs_edge;

      if (hs_edge) begin
        h_cnt   <= '0;
        act_cnt <= '0;
        x       <= '0;
        h_seen  <= 1'b1;
        if (h_seen) begin
          h_meas <= h_period;
          a_meas <= act_cnt;
        end
      end else begin
        if (h_cnt != CNT_MAX)
          h_cnt <= h_cnt + 11'd1;
        if (!bl_r && (act_cnt != CNT_MAX))
          act_cnt <= act_cnt + 11'd1;
        if (!bl_r && (x != X_MAX))
          x <= x + 10'd1;
      end

      // an hsync edge coinciding with vsync opens the new frame
      if (vs_edge) begin
        v_meas <= v_cnt;
        v_cnt  <= hs_edge ? 9'd1 : 9'd0;
        va_cnt <= (hs_edge && line_act) ? 9'd1 : 9'd0;
        y      <= '0;
      end else if (hs_edge) begin
        if (v_cnt != V_MAX)
          v_cnt <= v_cnt + 9'd1;
        if (line_act && (va_cnt != V_MAX))
          va_cnt <= va_cnt + 9'd1;
        if (line_act && (y != V_MAX))
          y <= y + 9'd1;
      end

      if (vs_edge)
        frame_bad <= line_bad;
      else if (line_bad)
        frame_bad <= 1'b1;

      if (hs_edge)
        to_flag <= 1'b0;
      else if (timeout)
        to_flag <= 1'b1;

      err_cnt <= (err_sum > 10'd255) ? 8'd255 : err_sum[7:0];
    end
  end

  assign mon.locked    = (state == LOCKED);
  assign mon.pix_valid = (state == LOCKED) && !bl_r;
  assign mon.x         = x;
  assign mon.y         = y;
  assign mon.frame_stb = frame_stb;
  assign mon.h_meas    = h_meas;
  assign mon.a_meas    = a_meas;
  assign mon.v_meas    = v_meas;
  assign mon.err_cnt   = err_cnt;

endmodule

// File: doc/vga_timing_monitor.md
Name: vga_timing_monitor

Overview:
- Sink-side checker for the CPLD VGA timing generator's output stream (hsync, vsync, blank, shload_n), clocked on the same pclk.
- Measures line and frame geometry and locks when that geometry matches the configured mode.
- Reconstructs the active-area pixel position (x, y) and counts timing violations.
- Used in simulation benches and as an on-board self-check.

Parameters:
- H_TOTAL, 800: expected pclk cycles per line.
- H_ACTIVE, 640: expected non-blank pixels per line.
- V_TOTAL, 449: expected lines per frame.
- V_ACTIVE, 400: expected lines containing active pixels.
- HSYNC_ACT, 0: hsync active level (0 = active-low).
- VSYNC_ACT, 1: vsync active level (1 = active-high).

Ports:
- pclk in 1: pixel clock; all logic rises on posedge.
- rst_n in 1: asynchronous active-low reset.
- hsync in 1: horizontal sync from generator.
- vsync in 1: vertical sync from generator.
- blank in 1: 1 = blanking, 0 = active pixel.
- locked out 1: geometry matches parameters.
- x out 10: active pixel index within line.
- y out 9: active line index within frame.
- pix_valid out 1: locked & active pixel (x, y meaningful).
- frame_stb out 1: one-cycle pulse per vsync leading edge.
- h_meas out 11: last measured line period, pclks.
- a_meas out 11: last measured active pixels per line.
- v_meas out 9: last measured lines per frame.
- err_cnt out 8: saturating violation counter.

Behaviour:
- Reset: all outputs 0; FSM in SEARCH; all counters 0.
- Input stage:
  - hsync, vsync and blank are registered once.
  - A leading edge is the registered value changing to its active level.
  - All responses below occur one cycle after the edge reaches the register, i.e. two pclks after the pin change.
- Horizontal counting:
  - h_cnt increments every pclk and saturates at 2047.
  - On an hsync edge, when a previous hsync edge has been seen: h_meas <= h_cnt + 1, a_meas <= act_cnt, then h_cnt and act_cnt clear.
  - act_cnt counts cycles with blank = 0 and saturates at 2047.
- Vertical counting:
  - v_cnt increments on each hsync edge and saturates at 511.
  - On a vsync edge: v_meas <= v_cnt; frame_stb = 1 for one cycle.
  - If an hsync edge falls in the same cycle as the vsync edge, it belongs to the new frame: v_cnt <= 1; otherwise v_cnt <= 0.
- Active line count: va_cnt increments once per line that contained at least one blank = 0 cycle, evaluated at that line's closing hsync edge.
- Position:
  - x increments on each blank = 0 cycle and clears on every hsync edge.
  - y clears on each vsync edge and increments at an hsync edge closing a line that had active pixels.
  - pix_valid = locked & ~blank_r.
- Line check: a closed line is bad if h_meas != H_TOTAL or a_meas is neither 0 nor H_ACTIVE. Bad lines set the sticky flag frame_bad, which clears at each vsync edge.
- Frame check, at the vsync edge: frame is good when frame_bad = 0, v_cnt == V_TOTAL and va_cnt == V_ACTIVE.
- FSM:
  - SEARCH: on the first vsync edge -> MEASURE.
  - MEASURE: at the next vsync edge, good -> LOCKED (locked = 1 the following cycle); bad -> stay in MEASURE and err_cnt++.
  - LOCKED: a bad line -> SEARCH immediately with locked = 0 and err_cnt++. A bad frame at the vsync edge does the same.
  - Timeout: h_cnt reaching 2047 in any state -> SEARCH with locked = 0; err_cnt++ once per timeout episode.
- err_cnt saturates at 255 and clears only on reset.
- Reset asserted mid-frame returns every register to its reset value immediately; re-lock needs two complete vsync edges.

Optional Feature:
- SHLOAD_CHECK_EN defined:
  - Adds input port shload_n (1 bit) and output shload_err (1 bit, sticky, reset 0).
  - During active pixels, shload_n must be low exactly when x[2:0] == 3'b111 and high otherwise.
  - Any mismatch sets shload_err and increments err_cnt, at most once per line.
  - shload_n is ignored during blanking.
- Undefined: neither port exists and no shload check is made.

Test Plan:
- Nominal 640x400 stream (800x449, 640 active, 400 active lines), 3 frames -> locked = 1 one cycle after the 2nd vsync edge; h_meas = 800, a_meas = 640, v_meas = 449, err_cnt = 0.
- While locked, a single line lengthened to 801 -> locked = 0 at that line's closing hsync edge; err_cnt = 1; relocks 2 vsync edges later.
- While locked, pixel (639, 399) -> pix_valid = 1, x = 639, y = 399; next blank cycle -> pix_valid = 0.
- hsync held inactive 2100 cycles -> locked = 0; err_cnt increments by exactly 1; h_cnt holds at 2047.
- hsync and vsync leading edges in the same cycle -> v_meas = previous frame's count; new frame v_cnt = 1; frame_stb pulses once.
- With SHLOAD_CHECK_EN defined, shload_n low at x[2:0] = 6 on one line -> shload_err = 1 and err_cnt increments by 1; a correctly phased stream leaves shload_err = 0.
